// File: rtl/memory_access_pkg.sv
// ============================================================================
// Module      : memory_access_pkg
// Description : Shared widths and load/store operation codes for the
//               memory access stage.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package memory_access_pkg;

    localparam int CPU_REGNO_WIDTH = 5;
    localparam int CPU_REG_WIDTH   = 32;
    localparam int CPU_ADDR_WIDTH  = 32;
    localparam int CPU_DATA_WIDTH  = 32;
    localparam int CPU_LSUOP_WIDTH = 2;

    localparam logic [CPU_LSUOP_WIDTH-1:0] CPU_LSU_IDLE  = 2'd0;
    localparam logic [CPU_LSUOP_WIDTH-1:0] CPU_LSU_BYTE  = 2'd1;
    localparam logic [CPU_LSUOP_WIDTH-1:0] CPU_LSU_HWORD = 2'd2;
    localparam logic [CPU_LSUOP_WIDTH-1:0] CPU_LSU_WORD  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/memory_access_mem_align.sv
// ============================================================================
// Module      : mem_align
// Description : Big-endian byte-lane steering: byte enables and replicated
//               write data for stores, lane extraction and extension for loads.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_align
    import memory_access_pkg::*;
(
    input  logic [CPU_LSUOP_WIDTH-1:0] i_op,
    input  logic [1:0]                 i_addr_lo,
    input  logic                       i_ext,
    input  logic [CPU_DATA_WIDTH-1:0]  i_wdata,
    input  logic [CPU_DATA_WIDTH-1:0]  i_rdata,
    output logic [3:0]                 o_ben,
    output logic [CPU_DATA_WIDTH-1:0]  o_wdata,
    output logic [CPU_DATA_WIDTH-1:0]  o_load
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane 0 (addr[1:0]==0) lives in the most significant byte.
    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[31:24];
            2'd1:    w_byte = i_rdata[23:16];
            2'd2:    w_byte = i_rdata[15:8];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    assign w_half = i_addr_lo[1] ? i_rdata[15:0] : i_rdata[31:16];

    always_comb begin
        o_ben   = 4'b0000;
        o_wdata = i_wdata;
        o_load  = i_rdata;
        case (i_op)
            CPU_LSU_BYTE: begin
                o_ben   = 4'b1000 >> i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_load  = {{24{i_ext & w_byte[7]}}, w_byte};
            end
            CPU_LSU_HWORD: begin
                o_ben   = i_addr_lo[1] ? 4'b0011 : 4'b1100;
                o_wdata = {2{i_wdata[15:0]}};
                o_load  = {{16{i_ext & w_half[15]}}, w_half};
            end
            CPU_LSU_WORD: begin
                o_ben   = 4'b1111;
                o_wdata = i_wdata;
                o_load  = i_rdata;
            end
            default: begin
                o_ben = 4'b0000;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/memory_access.sv
// ============================================================================
// Module      : memory_access
// Description : Memory access pipeline stage; registers the execute result,
//               runs the data-bus request/ready handshake and stalls the core.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module memory_access
    import memory_access_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_exec_stall,
    input  logic                       i_fetch_stall,
    output logic                       o_mem_stall,
    input  logic [CPU_REGNO_WIDTH-1:0] i_rd_no,
    input  logic [CPU_REG_WIDTH-1:0]   i_alu_result,
    input  logic [CPU_LSUOP_WIDTH-1:0] i_lsu_op,
    input  logic                       i_lsu_lns,
    input  logic                       i_lsu_ext,
    input  logic [CPU_DATA_WIDTH-1:0]  i_mem_data,
    output logic [CPU_REGNO_WIDTH-1:0] o_rd_no,
    output logic [CPU_REG_WIDTH-1:0]   o_rd_val,
    output logic [CPU_ADDR_WIDTH-1:0]  o_dbus_addr,
    output logic                       o_dbus_cmd,
    output logic                       o_dbus_rnw,
    output logic [CPU_DATA_WIDTH-1:0]  o_dbus_wdata,
    output logic [3:0]                 o_dbus_ben,
    input  logic                       i_dbus_rdy,
    input  logic [CPU_DATA_WIDTH-1:0]  i_dbus_data
);

    typedef enum logic [1:0] {
        c_ST_IDLE = 2'd0,
        c_ST_BUSY = 2'd1,
        c_ST_DONE = 2'd2
    } state_t;

    state_t                       r_state;
    state_t                       w_state_next;

    logic [CPU_REGNO_WIDTH-1:0]   r_rd_no;
    logic [CPU_REG_WIDTH-1:0]     r_alu;
    logic [CPU_LSUOP_WIDTH-1:0]   r_op;
    logic                         r_lns;
    logic                         r_ext;
    logic [CPU_DATA_WIDTH-1:0]    r_wdata;
    logic [CPU_DATA_WIDTH-1:0]    r_load;

    logic                         w_core_stall;
    logic                         w_complete;
    logic [3:0]                   w_ben;
    logic [CPU_DATA_WIDTH-1:0]    w_wdata;
    logic [CPU_DATA_WIDTH-1:0]    w_load;

    // Stall is a pure state decode so i_dbus_rdy never reaches it combinationally.
    assign o_mem_stall  = (r_state == c_ST_BUSY);
    assign w_core_stall = o_mem_stall | i_exec_stall | i_fetch_stall;
    assign w_complete   = (r_state == c_ST_BUSY) & i_dbus_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_no <= '0;
            r_alu   <= '0;
            r_op    <= CPU_LSU_IDLE;
            r_lns   <= 1'b0;
            r_ext   <= 1'b0;
            r_wdata <= '0;
        end else if (!w_core_stall) begin
            r_rd_no <= i_rd_no;
            r_alu   <= i_alu_result;
            r_op    <= i_lsu_op;
            r_lns   <= i_lsu_lns;
            r_ext   <= i_lsu_ext;
            r_wdata <= i_mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_load <= '0;
        end else if (w_complete) begin
            r_load <= w_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_BUSY: begin
                if (i_dbus_rdy) begin
                    w_state_next = c_ST_DONE;
                end
            end
            default: begin
                if (!w_core_stall) begin
                    w_state_next = (i_lsu_op != CPU_LSU_IDLE) ? c_ST_BUSY : c_ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        o_dbus_cmd = 1'b0;
        o_rd_no    = r_rd_no;
        o_rd_val   = r_alu;
        case (r_state)
            c_ST_BUSY: begin
                o_dbus_cmd = 1'b1;
                o_rd_no    = '0;
            end
            c_ST_DONE: begin
                if (r_lns) begin
                    o_rd_val = r_load;
                end else begin
                    o_rd_no = '0;
                end
            end
            default: begin
                o_dbus_cmd = 1'b0;
            end
        endcase
    end

    mem_align u_mem_align (
        .i_op      (r_op),
        .i_addr_lo (r_alu[1:0]),
        .i_ext     (r_ext),
        .i_wdata   (r_wdata),
        .i_rdata   (i_dbus_data),
        .o_ben     (w_ben),
        .o_wdata   (w_wdata),
        .o_load    (w_load)
    );

    // Bus fields come straight from the held registers, so they stay stable for the whole transaction.
    assign o_dbus_addr  = {r_alu[CPU_ADDR_WIDTH-1:2], 2'b00};
    assign o_dbus_rnw   = (r_op == CPU_LSU_IDLE) | r_lns;
    assign o_dbus_wdata = w_wdata;
    assign o_dbus_ben   = w_ben;

endmodule

`default_nettype wire

// File: tb/tb_memory_access.sv
// ============================================================================
// Module      : tb_memory_access
// Description : Self-checking bench for memory_access with a lane-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_memory_access;
    import memory_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_exec_stall, i_fetch_stall, o_mem_stall;
    logic [4:0]  i_rd_no, o_rd_no;
    logic [31:0] i_alu_result, i_mem_data, o_rd_val, o_dbus_addr, o_dbus_wdata, i_dbus_data;
    logic [1:0]  i_lsu_op;
    logic        i_lsu_lns, i_lsu_ext, o_dbus_cmd, o_dbus_rnw, i_dbus_rdy;
    logic [3:0]  o_dbus_ben;

    int n_checks = 0;
    int n_fail   = 0;
    int cmd_rises = 0;
    logic cmd_prev = 1'b0;

    memory_access dut (
        .clk(clk), .rst(rst),
        .i_exec_stall(i_exec_stall), .i_fetch_stall(i_fetch_stall), .o_mem_stall(o_mem_stall),
        .i_rd_no(i_rd_no), .i_alu_result(i_alu_result), .i_lsu_op(i_lsu_op),
        .i_lsu_lns(i_lsu_lns), .i_lsu_ext(i_lsu_ext), .i_mem_data(i_mem_data),
        .o_rd_no(o_rd_no), .o_rd_val(o_rd_val), .o_dbus_addr(o_dbus_addr),
        .o_dbus_cmd(o_dbus_cmd), .o_dbus_rnw(o_dbus_rnw), .o_dbus_wdata(o_dbus_wdata),
        .o_dbus_ben(o_dbus_ben), .i_dbus_rdy(i_dbus_rdy), .i_dbus_data(i_dbus_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_dbus_cmd && !cmd_prev) cmd_rises <= cmd_rises + 1;
        cmd_prev <= o_dbus_cmd;
    end

    // Reference model: an access of size s bytes covers lanes [start, start+s), lane 0 = MSB.
    function automatic int acc_size(input logic [1:0] op);
        return (op == 2'd0) ? 0 : (1 << (int'(op) - 1));
    endfunction

    function automatic logic [3:0] exp_ben(input logic [1:0] op, input logic [1:0] a);
        int s, start;
        logic [3:0] b;
        b = 4'b0000;
        s = acc_size(op);
        if (s == 0) return b;
        start = (int'(a) / s) * s;
        for (int i = 0; i < 4; i++)
            if (i >= start && i < start + s) b[3-i] = 1'b1;
        return b;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] op, input logic [31:0] d);
        int s;
        logic [31:0] w;
        s = acc_size(op);
        if (s == 0) return d;
        w = '0;
        for (int i = 0; i < 4; i++)
            w[31-8*i -: 8] = d[8*(s-1-(i % s)) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] op, input logic [1:0] a,
                                             input logic ext, input logic [31:0] rd);
        int s, start;
        logic [31:0] v;
        logic [63:0] m;
        s = acc_size(op);
        start = (int'(a) / s) * s;
        v = '0;
        for (int j = 0; j < s; j++)
            v = (v << 8) | {24'h0, rd[31-8*(start+j) -: 8]};
        m = (64'd1 << (8*s)) - 64'd1;
        if (ext && v[8*s-1]) v = v | ~m[31:0];
        return v;
    endfunction

    task automatic bubble();
        i_lsu_op = 2'd0; i_rd_no = 5'd0; i_alu_result = 32'h0;
        i_lsu_lns = 1'b0; i_lsu_ext = 1'b0; i_mem_data = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_exec_stall = 1'b0; i_fetch_stall = 1'b0;
        i_rd_no = 5'd7; i_alu_result = $urandom; i_lsu_op = 2'd3;
        i_lsu_lns = 1'b0; i_lsu_ext = 1'b1; i_mem_data = $urandom;
        i_dbus_rdy = 1'b1; i_dbus_data = $urandom;
        repeat (3) @(negedge clk);
        n_checks++; if (o_mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", o_mem_stall); end
        n_checks++; if (o_dbus_cmd !== 1'b0) begin n_fail++; $display("FAIL reset_cmd: got %b want 0", o_dbus_cmd); end
        n_checks++; if (o_rd_no !== 5'd0 || o_rd_val !== 32'h0) begin n_fail++; $display("FAIL reset_rd: got %0d/%h want 0/0", o_rd_no, o_rd_val); end
        n_checks++; if (o_dbus_addr !== 32'h0 || o_dbus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_bus: got %h/%h want 0/0", o_dbus_addr, o_dbus_wdata); end
        n_checks++; if (o_dbus_ben !== 4'b0000 || o_dbus_rnw !== 1'b1) begin n_fail++; $display("FAIL reset_ben_rnw: got %b/%b want 0000/1", o_dbus_ben, o_dbus_rnw); end
        rst = 1'b0; i_dbus_rdy = 1'b0;
        bubble();
    endtask

    task automatic run_alu(input logic [4:0] rd, input logic [31:0] val, input int stall_cycles);
        @(negedge clk);
        i_rd_no = rd; i_alu_result = val; i_lsu_op = 2'd0; i_mem_data = $urandom;
        i_dbus_rdy = 1'($urandom); i_dbus_data = $urandom;
        @(negedge clk);
        n_checks++; if (o_rd_no !== rd || o_rd_val !== val) begin n_fail++; $display("FAIL alu_result: got %0d/%h want %0d/%h", o_rd_no, o_rd_val, rd, val); end
        n_checks++; if (o_dbus_cmd !== 1'b0 || o_mem_stall !== 1'b0) begin n_fail++; $display("FAIL alu_cmd: got cmd=%b stall=%b want 0/0", o_dbus_cmd, o_mem_stall); end
        for (int s = 0; s < stall_cycles; s++) begin
            i_exec_stall = 1'b1;
            i_rd_no = $urandom; i_alu_result = $urandom; i_lsu_op = 2'($urandom);
            i_lsu_lns = 1'($urandom);
            @(negedge clk);
            n_checks++; if (o_rd_no !== rd || o_rd_val !== val || o_dbus_cmd !== 1'b0) begin n_fail++; $display("FAIL alu_hold: got %0d/%h cmd=%b want %0d/%h cmd=0", o_rd_no, o_rd_val, o_dbus_cmd, rd, val); end
        end
        i_exec_stall = 1'b0; i_dbus_rdy = 1'b0;
        bubble();
    endtask

    task automatic run_mem(input logic [4:0] rd, input logic [31:0] addr, input logic [1:0] op,
                           input logic lns, input logic ext, input logic [31:0] data,
                           input logic [31:0] rdata, input int delay, input int hold);
        int base;
        logic [4:0]  exp_rd;
        logic [31:0] exp_val;
        @(negedge clk);
        i_rd_no = rd; i_alu_result = addr; i_lsu_op = op; i_lsu_lns = lns;
        i_lsu_ext = ext; i_mem_data = data; i_dbus_rdy = 1'b0;
        i_exec_stall = 1'b0; i_fetch_stall = 1'b0;
        base = cmd_rises;
        @(negedge clk);
        bubble();
        for (int c = 0; c <= delay; c++) begin
            n_checks++; if (o_dbus_cmd !== 1'b1 || o_mem_stall !== 1'b1) begin n_fail++; $display("FAIL busy_cmd_stall: cycle %0d got %b/%b want 1/1", c, o_dbus_cmd, o_mem_stall); end
            n_checks++; if (o_dbus_addr !== {addr[31:2], 2'b00} || o_dbus_rnw !== lns) begin n_fail++; $display("FAIL busy_addr_rnw: got %h/%b want %h/%b", o_dbus_addr, o_dbus_rnw, {addr[31:2], 2'b00}, lns); end
            n_checks++; if (o_dbus_ben !== exp_ben(op, addr[1:0])) begin n_fail++; $display("FAIL busy_ben: got %b want %b", o_dbus_ben, exp_ben(op, addr[1:0])); end
            n_checks++; if (o_dbus_wdata !== exp_wdata(op, data)) begin n_fail++; $display("FAIL busy_wdata: got %h want %h", o_dbus_wdata, exp_wdata(op, data)); end
            n_checks++; if (o_rd_no !== 5'd0) begin n_fail++; $display("FAIL busy_rd_no: got %0d want 0", o_rd_no); end
            if (c == delay) begin i_dbus_rdy = 1'b1; i_dbus_data = rdata; end
            else            begin i_dbus_rdy = 1'b0; i_dbus_data = $urandom; end
            @(negedge clk);
        end
        exp_rd  = lns ? rd : 5'd0;
        exp_val = exp_load(op, addr[1:0], ext, rdata);
        for (int h = 0; h <= hold; h++) begin
            n_checks++; if (o_dbus_cmd !== 1'b0 || o_mem_stall !== 1'b0) begin n_fail++; $display("FAIL done_cmd_stall: hold %0d got %b/%b want 0/0", h, o_dbus_cmd, o_mem_stall); end
            n_checks++; if (o_rd_no !== exp_rd) begin n_fail++; $display("FAIL done_rd_no: got %0d want %0d", o_rd_no, exp_rd); end
            if (lns) begin
                n_checks++; if (o_rd_val !== exp_val) begin n_fail++; $display("FAIL done_load_val: got %h want %h", o_rd_val, exp_val); end
            end
            i_fetch_stall = (h != hold);
            i_dbus_rdy = 1'($urandom); i_dbus_data = $urandom;
            @(negedge clk);
        end
        i_dbus_rdy = 1'b0;
        n_checks++; if (cmd_rises - base !== 1) begin n_fail++; $display("FAIL cmd_pulses: got %0d want 1", cmd_rises - base); end
        n_checks++; if (o_rd_no !== 5'd0 || o_dbus_cmd !== 1'b0) begin n_fail++; $display("FAIL after_done: got rd=%0d cmd=%b want 0/0", o_rd_no, o_dbus_cmd); end
    endtask

    task automatic test_directed();
        run_alu(5'd5, 32'h0000_1234, 2);
        run_mem(5'd9, 32'h0000_0103, 2'd1, 1'b0, 1'b0, 32'hAABB_CCDD, 32'h0, 2, 0);
        run_mem(5'd3, 32'h0000_0202, 2'd2, 1'b1, 1'b1, 32'h0, 32'h1234_8001, 3, 0);
        run_mem(5'd3, 32'h0000_0202, 2'd2, 1'b1, 1'b0, 32'h0, 32'h1234_8001, 3, 0);
        run_mem(5'd4, 32'h0000_0301, 2'd1, 1'b1, 1'b1, 32'h0, 32'h11A2_3344, 0, 0);
    endtask

    task automatic test_done_hold();
        run_mem(5'd12, 32'h0000_0400, 2'd3, 1'b1, 1'b0, 32'h0, 32'hCAFE_F00D, 1, 3);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        i_rd_no = 5'd6; i_alu_result = 32'h0000_0502; i_lsu_op = 2'd2;
        i_lsu_lns = 1'b1; i_lsu_ext = 1'b0; i_mem_data = 32'h0;
        @(negedge clk);
        i_dbus_rdy = 1'b1; i_dbus_data = 32'h0000_BEEF;
        i_rd_no = 5'd7; i_alu_result = 32'h0000_0600; i_lsu_op = 2'd3;
        i_lsu_lns = 1'b1; i_lsu_ext = 1'b0;
        @(negedge clk);
        n_checks++; if (o_dbus_cmd !== 1'b0 || o_rd_val !== 32'h0000_BEEF || o_rd_no !== 5'd6) begin n_fail++; $display("FAIL b2b_first_done: got cmd=%b %0d/%h want 0 6/0000beef", o_dbus_cmd, o_rd_no, o_rd_val); end
        i_dbus_rdy = 1'b0;
        @(negedge clk);
        bubble();
        n_checks++; if (o_dbus_cmd !== 1'b1 || o_dbus_addr !== 32'h0000_0600 || o_rd_no !== 5'd0) begin n_fail++; $display("FAIL b2b_second_busy: got cmd=%b addr=%h rd=%0d want 1/00000600/0", o_dbus_cmd, o_dbus_addr, o_rd_no); end
        i_dbus_rdy = 1'b1; i_dbus_data = 32'h1357_9BDF;
        @(negedge clk);
        i_dbus_rdy = 1'b0;
        n_checks++; if (o_rd_val !== 32'h1357_9BDF || o_rd_no !== 5'd7) begin n_fail++; $display("FAIL b2b_second_done: got %0d/%h want 7/13579bdf", o_rd_no, o_rd_val); end
        @(negedge clk);
    endtask

    task automatic test_rst_busy();
        @(negedge clk);
        i_rd_no = 5'd2; i_alu_result = 32'h0000_0700; i_lsu_op = 2'd3;
        i_lsu_lns = 1'b0; i_mem_data = 32'h5555_AAAA; i_dbus_rdy = 1'b0;
        @(negedge clk);
        bubble();
        n_checks++; if (o_dbus_cmd !== 1'b1) begin n_fail++; $display("FAIL rst_busy_pre: got cmd=%b want 1", o_dbus_cmd); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (o_dbus_cmd !== 1'b0 || o_mem_stall !== 1'b0 || o_rd_no !== 5'd0) begin n_fail++; $display("FAIL rst_busy_post: got cmd=%b stall=%b rd=%0d want 0/0/0", o_dbus_cmd, o_mem_stall, o_rd_no); end
        run_mem(5'd8, 32'h0000_0040, 2'd3, 1'b1, 1'b1, 32'h0, 32'h8765_4321, 1, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                run_alu(5'($urandom), $urandom, $urandom_range(0, 2));
            end else begin
                run_mem(5'($urandom), $urandom, 2'($urandom_range(1, 3)), 1'($urandom),
                        1'($urandom), $urandom, $urandom,
                        $urandom_range(0, 3), $urandom_range(0, 2));
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_done_hold();
        test_back_to_back();
        test_rst_busy();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/memory_access.md
# memory_access

Memory access pipeline stage of the Ultiparc CPU core. It sits directly downstream of the execute stage and upstream of register writeback. It registers the execute-stage result and drives the data-bus request/ready handshake for loads and stores, including byte-lane steering and load extension. While a bus transaction is outstanding it stalls the core.

## Interface
Parameters: none. Widths come from `CPU_*_WIDTH` in cpu_common.vh.
- clk  in  1  core clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- i_exec_stall  in  1  stall from execute stage
- i_fetch_stall  in  1  stall from fetch stage
- o_mem_stall  out  1  stall request from this stage
- i_rd_no  in  CPU_REGNO_WIDTH  destination register from execute
- i_alu_result  in  CPU_REG_WIDTH  ALU result, which is also the effective address
- i_lsu_op  in  CPU_LSUOP_WIDTH  IDLE=0, BYTE=1, HWORD=2, WORD=3
- i_lsu_lns  in  1  1 = load, 0 = store
- i_lsu_ext  in  1  load sign-extend (1) or zero-extend (0)
- i_mem_data  in  CPU_DATA_WIDTH  store data (rt)
- o_rd_no  out  CPU_REGNO_WIDTH  writeback register; 0 means no write
- o_rd_val  out  CPU_REG_WIDTH  writeback value
- o_dbus_addr  out  CPU_ADDR_WIDTH  word-aligned address, {addr[31:2],2'b00}
- o_dbus_cmd  out  1  request valid
- o_dbus_rnw  out  1  1 = read, 0 = write
- o_dbus_wdata  out  CPU_DATA_WIDTH  write data, lane-replicated
- o_dbus_ben  out  4  byte enables; bit 3 = bits 31:24
- i_dbus_rdy  in  1  transaction complete
- i_dbus_data  in  CPU_DATA_WIDTH  read data, valid when i_dbus_rdy is high

## Operation
- core_stall = o_mem_stall | i_exec_stall | i_fetch_stall.
- Input registers (rd_no, alu, op, lns, ext, wdata) capture on every edge with !core_stall and hold otherwise.
- FSM states:
  - IDLE: the registered op is not a memory op, or nothing is pending.
  - BUSY: a bus transaction is outstanding.
  - DONE: the transaction has completed and the stage waits for the pipeline to advance.
- Transitions:
  - Capture with i_lsu_op != IDLE → BUSY.
  - Capture with i_lsu_op == IDLE → IDLE.
  - BUSY & i_dbus_rdy → DONE.
  - DONE & !core_stall → next state chosen by the op being captured.
  - IDLE & !core_stall → same rule.
- BUSY behaviour:
  - o_dbus_cmd=1 and o_mem_stall=1.
  - addr, rnw, wdata and ben are held stable from registers until i_dbus_rdy.
  - o_rd_no=0.
- DONE behaviour:
  - o_dbus_cmd=0 and o_mem_stall=0.
  - Load: o_rd_no=rd_no_r and o_rd_val=load_r.
  - Store: o_rd_no=0.
- IDLE behaviour: o_rd_no=rd_no_r, o_rd_val=alu_r, o_mem_stall=0, o_dbus_cmd=0.
- Byte order is big-endian. Byte at addr[1:0]=0 is bits 31:24.
  - BYTE: ben = 4'b1000 >> addr[1:0]; wdata = {4{d[7:0]}}.
  - HWORD: ben = addr[1] ? 4'b0011 : 4'b1100; wdata = {2{d[15:0]}}; addr[0] is ignored.
  - WORD: ben = 4'b1111; wdata = d; addr[1:0] are ignored.
- Loads:
  - The selected lane is right-justified.
  - ext=1 replicates the lane MSB into the upper bits; ext=0 fills them with zero.
  - load_r is latched on the BUSY & i_dbus_rdy edge.
- Loads use ben exactly as stores do.
- No alignment exceptions are raised.

## Timing
- Reset values: state=IDLE, op_r=IDLE, all data registers 0. Resulting outputs:
  - o_mem_stall=0, o_dbus_cmd=0
  - o_rd_no=0, o_rd_val=0
  - o_dbus_addr=0, o_dbus_wdata=0
  - o_dbus_ben=0, o_dbus_rnw=1
- Non-memory op: the result appears on o_rd_no/o_rd_val in the cycle after the capture edge, a 1-cycle latency.
- Memory op with i_dbus_rdy already high in the first BUSY cycle:
  - Cycle 1 after capture is BUSY.
  - Cycle 2 is DONE and the load data is visible.
  - Minimum latency is 2 cycles.
- Each cycle i_dbus_rdy stays low adds one cycle.
- o_mem_stall is a registered-state decode (state==BUSY). There is no combinational path from i_dbus_rdy.
- i_dbus_rdy outside BUSY is ignored.
- DONE held by another stall: no re-issue of the request, and outputs stay stable.
- Back-to-back memory ops: DONE→BUSY on a single edge, so o_dbus_cmd gaps for exactly one cycle.
- rst during BUSY: state → IDLE on the next edge and cmd drops. The abandoned transaction is the bus's responsibility.

## Structure
- Add CPU_LSU_IDLE/BYTE/HWORD/WORD to cpu_const.vh if absent. Width is CPU_LSUOP_WIDTH=2.
- FSM state encodings are local parameters of this module.
- Lane steering (ben/wdata generation and load extraction) goes in one combinational sub-module, mem_align, which is instantiated once.

## Test plan
- ALU op with rd=5, alu=0x1234: o_rd_no=5 and o_rd_val=0x1234 one cycle after capture; o_dbus_cmd stays 0.
- Store BYTE at addr 0x103 with data 0xAABBCCDD: addr=0x100, ben=0001, wdata=0xDDDDDDDD, rnw=0. Stall holds until rdy; o_rd_no=0 throughout.
- Load HWORD with ext=1 at 0x202, rdata=0x1234_8001, rdy delayed 3 cycles: stall lasts 4 cycles, then o_rd_val=0xFFFF8001. Repeat with ext=0: 0x00008001.
- Load BYTE at 0x301, rdata=0x11A2_3344, ext=1: o_rd_val=0xFFFFFFA2.
- Load completes while i_fetch_stall is high for 3 cycles: stays in DONE, exactly one cmd pulse sequence, output stable; advances when the stall clears.
- rst asserted mid-BUSY: next cycle o_dbus_cmd=0, o_mem_stall=0, o_rd_no=0; a subsequent WORD load completes normally.
